// File: rtl/mesi_isc_fifo_pkg.sv
// Shared definitions for the parametrised MESI ISC FIFO:
// default sizes, count-width helper and error-kind enum for monitors.
package mesi_isc_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_SIZE  = 4;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2
  } fifo_err_e;

  // Width needed to hold an occupancy of 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mesi_isc_fifo_ptr.sv
// Modulo-FIFO_SIZE pointer: wraps explicitly from FIFO_SIZE-1 to 0 so that
// non-power-of-two depths never rely on natural binary overflow.
module mesi_isc_fifo_ptr
  import mesi_isc_fifo_pkg::*;
#(
  parameter int FIFO_SIZE = DEF_FIFO_SIZE,
  parameter int PTR_W     = $clog2(FIFO_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic [PTR_W-1:0] ptr_next_o
);

  // Next pointer value: hold, or advance with explicit wrap at the last slot.
  always_comb begin
    ptr_next_o = ptr_o;
    if (inc_i) begin
      ptr_next_o = (ptr_o == PTR_W'(FIFO_SIZE - 1)) ? '0 : ptr_o + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_o <= '0;
    else     ptr_o <= ptr_next_o;
  end

endmodule

// File: rtl/mesi_isc_param_fifo.sv
// Parametrised MESI ISC FIFO with occupancy count, almost-full/empty flags
// and sticky overflow/underflow flags. Illegal pushes/pops are absorbed and
// flagged. Optional macro MESI_ISC_FIFO_FWFT_EN selects first-word-fall-through
// output; otherwise data_o is registered with one cycle of read latency.
module mesi_isc_param_fifo
  import mesi_isc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int FIFO_SIZE        = DEF_FIFO_SIZE,
  parameter int ALMOST_FULL_THR  = 3,
  parameter int ALMOST_EMPTY_THR = 1,
  parameter int PTR_W            = $clog2(FIFO_SIZE),
  parameter int CNT_W            = cnt_width(FIFO_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clr_err_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  status_empty_o,
  output logic                  status_full_o,
  output logic                  status_almost_full_o,
  output logic                  status_almost_empty_o,
  output logic [CNT_W-1:0]      fifo_count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]      count_next;
  logic                  push_ok, pop_ok;
  logic                  unused_ptr_next;

  // A push into a full FIFO is legal only when a pop frees a slot this cycle.
  assign push_ok = wr_i & (~status_full_o | rd_i);
  assign pop_ok  = rd_i & ~status_empty_o;

  assign count_next = fifo_count_o + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // Next-pointer outputs are not needed here; storage addresses use current pointers.
  assign unused_ptr_next = ^{wr_ptr_next, rd_ptr_next};

  mesi_isc_fifo_ptr #(.FIFO_SIZE(FIFO_SIZE), .PTR_W(PTR_W)) u_wr_ptr (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (push_ok),
    .ptr_o      (wr_ptr),
    .ptr_next_o (wr_ptr_next)
  );

  mesi_isc_fifo_ptr #(.FIFO_SIZE(FIFO_SIZE), .PTR_W(PTR_W)) u_rd_ptr (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (pop_ok),
    .ptr_o      (rd_ptr),
    .ptr_next_o (rd_ptr_next)
  );

  // Entry storage; intentionally not reset. Writes are masked during reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= data_i;
  end

  // Occupancy and status flags, all registered from count_next so they line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count_o          <= '0;
      status_empty_o        <= 1'b1;
      status_full_o         <= 1'b0;
      status_almost_empty_o <= 1'b1;
      status_almost_full_o  <= (ALMOST_FULL_THR == 0);
    end else begin
      fifo_count_o          <= count_next;
      status_empty_o        <= (count_next == '0);
      status_full_o         <= (count_next == CNT_W'(FIFO_SIZE));
      status_almost_empty_o <= (count_next <= CNT_W'(ALMOST_EMPTY_THR));
      status_almost_full_o  <= (count_next >= CNT_W'(ALMOST_FULL_THR));
    end
  end

  // Sticky error flags; a new error event takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_i && status_full_o && !rd_i) overflow_o <= 1'b1;
      else if (clr_err_i)                 overflow_o <= 1'b0;
      if (rd_i && status_empty_o)         underflow_o <= 1'b1;
      else if (clr_err_i)                 underflow_o <= 1'b0;
    end
  end

`ifdef MESI_ISC_FIFO_FWFT_EN
  // Head entry falls through whenever the FIFO holds data; zero when empty.
  always_comb begin
    data_o = '0;
    if (!status_empty_o) data_o = mem[rd_ptr];
  end
`else
  // Registered read port: head captured on a successful pop, held otherwise.
  always_ff @(posedge clk) begin
    if (rst)         data_o <= '0;
    else if (pop_ok) data_o <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_mesi_isc_param_fifo.sv
// Directed scoreboard bench for mesi_isc_param_fifo (FIFO_SIZE=5).
// Honours MESI_ISC_FIFO_FWFT_EN for read-data timing.
module tb_mesi_isc_param_fifo;

  localparam int DW = 32;
  localparam int FS = 5;
  localparam int CW = $clog2(FS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_i = 1'b0;
  logic          rd_i = 1'b0;
  logic          clr_err_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          status_empty_o, status_full_o;
  logic          status_almost_full_o, status_almost_empty_o;
  logic [CW-1:0] fifo_count_o;
  logic          overflow_o, underflow_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];

  mesi_isc_param_fifo #(
    .DATA_WIDTH       (DW),
    .FIFO_SIZE        (FS),
    .ALMOST_FULL_THR  (3),
    .ALMOST_EMPTY_THR (1)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .wr_i                  (wr_i),
    .rd_i                  (rd_i),
    .data_i                (data_i),
    .clr_err_i             (clr_err_i),
    .data_o                (data_o),
    .status_empty_o        (status_empty_o),
    .status_full_o         (status_full_o),
    .status_almost_full_o  (status_almost_full_o),
    .status_almost_empty_o (status_almost_empty_o),
    .fifo_count_o          (fifo_count_o),
    .overflow_o            (overflow_o),
    .underflow_o           (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [31:0] d,
                      input logic c, input logic rs);
    wr_i = w; rd_i = r; data_i = d; clr_err_i = c; rst = rs;
    @(posedge clk);
    #1;
    wr_i = 1'b0; rd_i = 1'b0; clr_err_i = 1'b0; rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0);
    sb.push_back(d);
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    e = sb.pop_front();
`ifdef MESI_ISC_FIFO_FWFT_EN
    check(tag, data_o, e);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
`else
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    check(tag, data_o, e);
`endif
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    check("rst_empty", 32'(status_empty_o), 32'd1);
    check("rst_full", 32'(status_full_o), 32'd0);
    check("rst_aempty", 32'(status_almost_empty_o), 32'd1);
    check("rst_afull", 32'(status_almost_full_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_udf", 32'(underflow_o), 32'd0);
    check("rst_data", data_o, 32'd0);

    // Fill with 0xA0..0xA4, watching count and flags
    for (int i = 0; i < FS; i++) begin
      push(32'hA0 + 32'(i));
      check("fill_count", 32'(fifo_count_o), 32'(i + 1));
      check("fill_afull", 32'(status_almost_full_o), 32'(i + 1 >= 3));
      check("fill_aempty", 32'(status_almost_empty_o), 32'(i + 1 <= 1));
      check("fill_full", 32'(status_full_o), 32'(i + 1 == FS));
      check("fill_empty", 32'(status_empty_o), 32'd0);
    end

    // Drain in order
    for (int i = 0; i < FS; i++) begin
      pop_chk("drain_data");
      check("drain_count", 32'(fifo_count_o), 32'(FS - 1 - i));
    end
    check("drain_empty", 32'(status_empty_o), 32'd1);
    check("drain_udf", 32'(underflow_o), 32'd0);

    // Pointer wrap: push 3 / pop 3, four rounds, data 0x00..0x0B
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) push(32'(r * 3 + k));
      check("wrap_count", 32'(fifo_count_o), 32'd3);
      for (int k = 0; k < 3; k++) pop_chk("wrap_data");
    end
    check("wrap_empty", 32'(status_empty_o), 32'd1);

    // Overflow on a full FIFO
    for (int i = 0; i < FS; i++) push(32'hB0 + 32'(i));
    step(1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b0);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_count", 32'(fifo_count_o), 32'd5);
    check("ovf_full", 32'(status_full_o), 32'd1);

    // Push and pop together while full: head leaves, no new error
    begin
      logic [31:0] e;
      e = sb.pop_front();
`ifdef MESI_ISC_FIFO_FWFT_EN
      check("fullrw_data", data_o, e);
      step(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0);
`else
      step(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0);
      check("fullrw_data", data_o, e);
`endif
      sb.push_back(32'hC0);
    end
    check("fullrw_count", 32'(fifo_count_o), 32'd5);
    check("fullrw_udf", 32'(underflow_o), 32'd0);
    check("fullrw_ovf_sticky", 32'(overflow_o), 32'd1);

    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("clr_ovf", 32'(overflow_o), 32'd0);
    // Clear coinciding with a fresh overflow: the error wins
    step(1'b1, 1'b0, 32'hEE, 1'b1, 1'b0);
    check("clr_vs_ovf", 32'(overflow_o), 32'd1);
    check("clr_vs_ovf_count", 32'(fifo_count_o), 32'd5);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("clr_ovf2", 32'(overflow_o), 32'd0);

    // Drain: B1..B4 then C0; 0xDEAD and 0xEE never appear
    for (int i = 0; i < FS; i++) pop_chk("ovf_drain_data");
    check("ovf_drain_empty", 32'(status_empty_o), 32'd1);

    // Read and write together on empty: underflow, push lands, no bypass
    step(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
    sb.push_back(32'h55);
    check("udf_flag", 32'(underflow_o), 32'd1);
    check("udf_count", 32'(fifo_count_o), 32'd1);
    check("udf_ovf", 32'(overflow_o), 32'd0);
`ifdef MESI_ISC_FIFO_FWFT_EN
    check("udf_data_fwft", data_o, 32'h55);
`else
    check("udf_data_held", data_o, 32'hC0);
`endif
    pop_chk("udf_next_pop");
    check("udf_sticky", 32'(underflow_o), 32'd1);

    // Reset mid-operation with count=3; wr/rd in the reset cycle ignored
    for (int i = 0; i < 3; i++) push(32'h11 + 32'(i));
    check("pre_rst_count", 32'(fifo_count_o), 32'd3);
    step(1'b1, 1'b1, 32'h99, 1'b0, 1'b1);
    sb.delete();
    check("mrst_count", 32'(fifo_count_o), 32'd0);
    check("mrst_empty", 32'(status_empty_o), 32'd1);
    check("mrst_data", data_o, 32'd0);
    check("mrst_udf", 32'(underflow_o), 32'd0);
    check("mrst_ovf", 32'(overflow_o), 32'd0);

    // Single entry after reset travels through correctly
    push(32'h77);
`ifdef MESI_ISC_FIFO_FWFT_EN
    check("fwft_visible", data_o, 32'h77);
`endif
    pop_chk("single_pop");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("single_empty", 32'(status_empty_o), 32'd1);
`ifdef MESI_ISC_FIFO_FWFT_EN
    check("fwft_zero_when_empty", data_o, 32'd0);
`else
    check("single_data_held", data_o, 32'h77);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
